ksa_swap: RTL and testbench
===========================

Name: ksa_swap

Overview:
- Second stage of the RC4 decryption datapath; runs after s_memory_init has loaded S[i]=i into the 256x8 s_memory.
- Performs the RC4 key-scheduling loop: for i = 0..255, j = j + S[i] + key[i mod KEY_LENGTH], then swap S[i] and S[j].
- Drives the same single-port s_memory interface as the init stage; the top level muxes the two masters on the init/ksa finish flags.

Parameters:
- KEY_LENGTH, 3, number of secret-key bytes.
- Key byte k is taken from secret_key[8*(KEY_LENGTH-k)-1 -: 8], so byte 0 is the MSB byte.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset: reset=0 sampled on a clk edge resets the block.
- start  input  1  level; sampled in IDLE/DONE to begin a schedule pass.
- secret_key  input  8*KEY_LENGTH  key; must be stable from start until finish.
- address  output  8  s_memory address.
- data  output  8  s_memory write data.
- written_enable  output  1  s_memory write enable.
- q  input  8  s_memory read data; valid on the cycle after the address edge.
- finish  output  1  high while in DONE.

Behaviour:
- Reset (reset=0 at an edge):
  - State becomes IDLE; i=0, j=0, si=0, sj=0.
  - Outputs: address=0, data=0, written_enable=0, finish=0.
  - Reset has priority over every other event and may occur mid-pass; the memory is then left partially permuted and the top must re-run init before restarting.
- Registers: i[7:0], j[7:0], si[7:0], sj[7:0]. All sums are mod 256 (8-bit wrap; carry discarded).
- The key index is a separate counter k that cycles 0..KEY_LENGTH-1, resets with i, and advances when i increments. No divider is used.
- States, one clock each (8 cycles per iteration):
  - IDLE: outputs idle (written_enable=0, address=0). If start=1, clear i, j and k, then go to READ_I.
  - READ_I: address=i, written_enable=0.
  - WAIT_I: address=i held.
  - CALC_J: si<=q; j<=j+q+key[k].
  - READ_J: address=j.
  - WAIT_J: address=j held.
  - LATCH_J: sj<=q.
  - WRITE_I: address=i, data=sj, written_enable=1.
  - WRITE_J: address=j, data=si, written_enable=1.
    - If i==255, go to DONE.
    - Otherwise i<=i+1, advance k, go to READ_I.
  - DONE: finish=1, written_enable=0. If start=1, clear i, j, k and finish, then go to READ_I (re-run). Otherwise stay.
- Latency:
  - Start sampled at edge N; the pass enters READ_I after edge N.
  - DONE is entered, and finish=1, after edge N+2048.
- written_enable is high only in WRITE_I and WRITE_J: exactly 512 write cycles per pass.
- Boundary conditions:
  - i==j: WRITE_I writes S[i]=sj, then WRITE_J writes S[i]=si; net S[i] unchanged, which is correct RC4.
  - j wrap (e.g. 0xFF+0x01): the result is 0x00.
  - i==255 does not wrap to 0; the pass terminates.
  - start held high through a pass has no effect until DONE, where it immediately re-triggers a new pass.
  - secret_key changing mid-pass is undefined use; no checking is done.

Test Plan:
- Reset: hold reset=0 for 3 cycles during an active pass, then reset=1 -> address=0, written_enable=0, finish=0, state IDLE; no writes until start.
- Key 0x010203 on an identity memory:
  - Iteration 0: j=0x01; writes are (addr 0, data 0x01) then (addr 1, data 0x00).
  - Iteration 1: j=0x03; writes are (addr 1, data 0x03) then (addr 3, data 0x00).
- Key 0x000000, iteration 2: j=0x03 -> writes (addr 2, data 0x03) then (addr 3, data 0x02). Iterations 0 and 1 have i==j and write the same value back.
- Wrap, key 0xFF0000:
  - Iteration 0: j=0xFF -> S[0]=0xFF, S[255]=0x00.
  - Iteration 1: j=0x00 -> S[1]=0xFF, S[0]=0x01.
- Full pass with key 0x000249 against a software RC4 KSA model:
  - All 256 final bytes match.
  - finish rises exactly 2048 cycles after the start edge.
  - 512 write cycles are counted.
- DONE handling: start kept low -> finish stays 1 with no memory activity; pulse start -> finish drops next cycle and a new pass begins at i=0, j=0.

Source files
------------

// File: rtl/ksa_swap.sv
// RC4 key-scheduling stage: permutes the 256-byte S table in place using the secret key.
// Each of the 256 iterations spends 8 clocks on the single-port s_memory (read S[i], read S[j], swap).
module ksa_swap #(
    parameter int unsigned KEY_LENGTH = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [8*KEY_LENGTH-1:0] secret_key,
    output logic [7:0]              address,
    output logic [7:0]              data,
    output logic                    written_enable,
    input  logic [7:0]              q,
    output logic                    finish
);

    localparam int unsigned KW = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;

    typedef enum logic [3:0] {
        StIdle, StReadI, StWaitI, StCalcJ, StReadJ, StWaitJ, StLatchJ, StWriteI, StWriteJ, StDone
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
    logic [KW-1:0]   k_q, k_d;
    logic [7:0]      key_byte;

    // Byte 0 is the most significant byte of secret_key.
    always_comb begin
        key_byte = 8'h00;
        for (int b = 0; b < int'(KEY_LENGTH); b++) begin
            if (k_q == KW'(b)) key_byte = secret_key[8*(int'(KEY_LENGTH)-b)-1 -: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            i_q     <= 8'h00;
            j_q     <= 8'h00;
            si_q    <= 8'h00;
            sj_q    <= 8'h00;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        si_d    = si_q;
        sj_d    = sj_q;
        k_d     = k_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    i_d     = 8'h00;
                    j_d     = 8'h00;
                    k_d     = '0;
                    state_d = StReadI;
                end
            end
            StReadI:  state_d = StWaitI;
            StWaitI:  state_d = StCalcJ;
            StCalcJ: begin
                si_d    = q;
                j_d     = j_q + q + key_byte;
                state_d = StReadJ;
            end
            StReadJ:  state_d = StWaitJ;
            StWaitJ:  state_d = StLatchJ;
            StLatchJ: begin
                sj_d    = q;
                state_d = StWriteI;
            end
            StWriteI: state_d = StWriteJ;
            StWriteJ: begin
                if (i_q == 8'hFF) begin
                    state_d = StDone;
                end else begin
                    i_d     = i_q + 8'd1;
                    k_d     = (k_q == KW'(KEY_LENGTH - 1)) ? '0 : k_q + 1'b1;
                    state_d = StReadI;
                end
            end
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        address        = 8'h00;
        data           = 8'h00;
        written_enable = 1'b0;
        finish         = 1'b0;
        unique case (state_q)
            StReadI, StWaitI:          address = i_q;
            StReadJ, StWaitJ:          address = j_q;
            StWriteI: begin
                address        = i_q;
                data           = sj_q;
                written_enable = 1'b1;
            end
            StWriteJ: begin
                address        = j_q;
                data           = si_q;
                written_enable = 1'b1;
            end
            StDone:                    finish = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ksa_swap.sv
// Bench for ksa_swap: behavioural s_memory, expected-write scoreboard and RC4 KSA reference.
module tb_ksa_swap;
    localparam int unsigned KL = 3;

    logic        clk = 1'b0;
    logic        reset, start, init_req;
    logic [23:0] secret_key;
    logic [7:0]  address, data, q;
    logic        written_enable, finish;

    always #5 clk = ~clk;

    ksa_swap #(.KEY_LENGTH(KL)) dut (
        .clk(clk), .reset(reset), .start(start), .secret_key(secret_key),
        .address(address), .data(data), .written_enable(written_enable), .q(q), .finish(finish)
    );

    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (init_req) begin
            for (int a = 0; a < 256; a++) mem[a] <= 8'(a);
        end else if (written_enable === 1'b1) begin
            mem[address] <= data;
        end
        q <= mem[address];
    end

    logic [15:0] exp_q[$];
    logic [15:0] mon_e;
    int checks = 0, errors = 0, writes_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every write cycle must match the next expected (address, data) pair.
    always @(negedge clk) begin
        if (written_enable === 1'b1) begin
            writes_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                         address, data);
            end else begin
                mon_e = exp_q.pop_front();
                check("write", {16'h0, address, data}, {16'h0, mon_e});
            end
        end
    end

    task automatic expect_w(input logic [7:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic reinit();
        @(negedge clk) init_req = 1'b1;
        @(negedge clk) init_req = 1'b0;
    endtask

    // Reset mid-pass, held for 3 edges, `cycles` edges after the start edge.
    task automatic abort_after(input int cycles);
        repeat (cycles) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        check("queue_drained", exp_q.size(), 0);
        @(negedge clk);
        check("rst_address", address, 8'h00);
        check("rst_we", written_enable, 1'b0);
        check("rst_finish", finish, 1'b0);
    endtask

    logic [7:0] s [256];
    logic [7:0] kb [3];
    logic [7:0] mj, tmp;
    int n;

    initial begin
        reset = 1'b0; start = 1'b0; init_req = 1'b0; secret_key = 24'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("reset_address", address, 8'h00);
        check("reset_data", data, 8'h00);
        check("reset_we", written_enable, 1'b0);
        check("reset_finish", finish, 1'b0);
        reinit();

        // Key 0x010203: iterations 0 and 1, then reset mid-pass.
        secret_key = 24'h010203;
        expect_w(8'h00, 8'h01); expect_w(8'h01, 8'h00);
        expect_w(8'h01, 8'h03); expect_w(8'h03, 8'h00);
        pulse_start();
        abort_after(16);
        repeat (10) begin
            @(negedge clk);
            check("idle_address", address, 8'h00);
        end
        reinit();

        // Key 0: i==j for iterations 0 and 1.
        secret_key = 24'h000000;
        expect_w(8'h00, 8'h00); expect_w(8'h00, 8'h00);
        expect_w(8'h01, 8'h01); expect_w(8'h01, 8'h01);
        expect_w(8'h02, 8'h03); expect_w(8'h03, 8'h02);
        pulse_start();
        abort_after(24);
        reinit();

        // j wrap: 0xFF + 0x01 -> 0x00.
        secret_key = 24'hFF0000;
        expect_w(8'h00, 8'hFF); expect_w(8'hFF, 8'h00);
        expect_w(8'h01, 8'hFF); expect_w(8'h00, 8'h01);
        pulse_start();
        abort_after(16);
        check("wrap_s0", mem[0], 8'h01);
        check("wrap_s1", mem[1], 8'hFF);
        check("wrap_s255", mem[255], 8'h00);
        reinit();

        // Full pass against a software KSA.
        secret_key = 24'h000249;
        kb[0] = 8'h00; kb[1] = 8'h02; kb[2] = 8'h49;
        for (int a = 0; a < 256; a++) s[a] = 8'(a);
        mj = 8'h00;
        for (int i = 0; i < 256; i++) begin
            mj = mj + s[i] + kb[i % 3];
            expect_w(8'(i), s[mj]);
            expect_w(mj, s[i]);
            tmp = s[i]; s[i] = s[mj]; s[mj] = tmp;
        end
        writes_seen = 0;
        pulse_start();
        n = 0;
        while (n < 3000 && finish !== 1'b1) begin
            @(posedge clk);
            n++;
            #1;
        end
        check("finish_latency", n, 2048);
        check("write_count", writes_seen, 512);
        check("queue_drained_full", exp_q.size(), 0);
        for (int a = 0; a < 256; a++) check("final_s", {a[7:0], mem[a]}, {a[7:0], s[a]});

        // DONE holds with start low, then re-triggers from i=0, j=0.
        repeat (20) begin
            @(negedge clk);
            check("done_finish", finish, 1'b1);
            check("done_we", written_enable, 1'b0);
        end
        mj = s[0] + kb[0];
        expect_w(8'h00, s[mj]);
        expect_w(mj, s[0]);
        pulse_start();
        check("rerun_finish", finish, 1'b0);
        check("rerun_address", address, 8'h00);
        abort_after(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
